// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch: owns the PC, issues word reads over req/ack,
// latches the returned word for decode and flags misaligned or timed-out fetches.
module instr_fetch_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_start,
    input  logic            pc_write,
    input  logic [XLEN-1:0] pc_next,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [31:0]     mem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc_cur,
    output logic [XLEN-1:0] pc_old,
    output logic [XLEN-1:0] pc_plus4,
    output logic            busy,
    output logic            fetch_fault,
    output logic [1:0]      fault_cause
);
    localparam int             CW      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(MEM_TIMEOUT - 1);
    localparam logic [31:0]    NOP     = 32'h0000_0013;

    typedef enum logic { IDLE, REQ } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            pend_vld;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] pc_eff;
    logic            redir;
    logic [XLEN-1:0] redir_pc;

    // Same-cycle pc_write takes effect before the alignment check in IDLE.
    assign pc_eff   = pc_write ? pc_next : pc_cur;
    // In REQ the most recent redirect wins, including one arriving with the ack.
    assign redir    = pc_write | pend_vld;
    assign redir_pc = pc_write ? pc_next : pend_pc;

    assign mem_req  = (state == REQ);
    assign busy     = (state == REQ);
    assign mem_addr = pc_cur;
    assign pc_plus4 = pc_old + XLEN'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc_cur      <= RESET_PC;
            pc_old      <= RESET_PC;
            instr       <= NOP;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fault_cause <= 2'd0;
            cnt         <= '0;
            pend_vld    <= 1'b0;
            pend_pc     <= '0;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pc_write) pc_cur <= pc_next;
                    if (fetch_start) begin
                        if (pc_eff[1:0] == 2'b00) begin
                            state       <= REQ;
                            fetch_fault <= 1'b0;
                            fault_cause <= 2'd0;
                            cnt         <= '0;
                            pend_vld    <= 1'b0;
                        end else begin
                            fetch_fault <= 1'b1;
                            fault_cause <= 2'd1;
                        end
                    end
                end
                REQ: begin
                    if (pc_write) begin
                        pend_vld <= 1'b1;
                        pend_pc  <= pc_next;
                    end
                    if (mem_ack) begin
                        instr       <= mem_rdata;
                        pc_old      <= pc_cur;
                        pc_cur      <= redir ? redir_pc : pc_cur + XLEN'(4);
                        instr_valid <= 1'b1;
                        pend_vld    <= 1'b0;
                        state       <= IDLE;
                    end else if (cnt == TO_LAST) begin
                        // Timeout leaves instr/pc_old alone; only a redirect moves the PC.
                        if (redir) pc_cur <= redir_pc;
                        fetch_fault <= 1'b1;
                        fault_cause <= 2'd2;
                        pend_vld    <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit: stimulus pushes expected fetch results,
// a negedge monitor pops and compares whenever instr_valid is seen.
module tb_instr_fetch_unit;
    logic        clk = 0;
    logic        reset, fetch_start, pc_write, mem_ack;
    logic [31:0] pc_next, mem_rdata;
    logic        mem_req, instr_valid, busy, fetch_fault;
    logic [31:0] mem_addr, instr, pc_cur, pc_old, pc_plus4;
    logic [1:0]  fault_cause;

    typedef struct { logic [31:0] instr; logic [31:0] pc_old; logic [31:0] pc_cur; } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_write(pc_write),
        .pc_next(pc_next), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid), .pc_cur(pc_cur),
        .pc_old(pc_old), .pc_plus4(pc_plus4), .busy(busy), .fetch_fault(fetch_fault),
        .fault_cause(fault_cause)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every instr_valid pulse must match the oldest expected fetch.
    always @(negedge clk) begin
        if (!reset && instr_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("instr",    instr,    e.instr);
                chk("pc_old",   pc_old,   e.pc_old);
                chk("pc_cur",   pc_cur,   e.pc_cur);
                chk("pc_plus4", pc_plus4, e.pc_old + 32'd4);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1; fetch_start = 0; pc_write = 0; mem_ack = 0;
        @(negedge clk);
        reset = 0;
    endtask

    // One fetch: optional pc_write with the start, `waits` unacked cycles, optional
    // mid-REQ redirect at wait index wr_at.
    task automatic fetch(input logic pw, input logic [31:0] pn, input int waits,
                         input logic [31:0] data, input logic [31:0] addr,
                         input logic [31:0] exp_pc, input int wr_at, input logic [31:0] wr_val);
        exp_t e;
        @(negedge clk);
        fetch_start = 1; pc_write = pw; pc_next = pn;
        e.instr = data; e.pc_old = addr; e.pc_cur = exp_pc;
        exp_q.push_back(e);
        @(negedge clk);
        fetch_start = 0; pc_write = 0;
        for (int i = 0; i <= waits; i++) begin
            chk("mem_req", {31'd0, mem_req}, 32'd1);
            chk("mem_addr", mem_addr, addr);
            pc_write  = (i == wr_at);
            pc_next   = wr_val;
            mem_ack   = (i == waits);
            mem_rdata = data;
            @(negedge clk);
        end
        mem_ack = 0; pc_write = 0;
        @(negedge clk);
        chk("valid_pulse", {31'd0, instr_valid}, 32'd0);
    endtask

    task automatic timeout_run(input int wr_at, input logic [31:0] wr_val,
                               input logic [31:0] exp_pc);
        @(negedge clk);
        fetch_start = 1;
        @(negedge clk);
        fetch_start = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || i == 15) chk("to_busy", {31'd0, busy}, 32'd1);
            pc_write    = (i == wr_at);
            pc_next     = wr_val;
            fetch_start = (i == 5);   // ignored while busy
            @(negedge clk);
        end
        pc_write = 0; fetch_start = 0;
        chk("to_busy_low", {31'd0, busy}, 32'd0);
        chk("to_fault", {31'd0, fetch_fault}, 32'd1);
        chk("to_cause", {30'd0, fault_cause}, 32'd2);
        chk("to_pc_cur", pc_cur, exp_pc);
    endtask

    initial begin
        reset = 1; fetch_start = 0; pc_write = 0; pc_next = 0; mem_ack = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        chk("rst_pc_cur", pc_cur, 32'h0);
        chk("rst_pc_old", pc_old, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_flags", {27'd0, instr_valid, mem_req, busy, fault_cause}, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);

        // Zero-wait fetch.
        fetch(0, 0, 0, 32'h0011_5093, 32'h0, 32'h4, -1, 0);

        // Three fetches with two wait states each, from reset.
        do_reset();
        fetch(0, 0, 2, 32'hAAAA_0001, 32'h0, 32'h4, -1, 0);
        fetch(0, 0, 2, 32'hAAAA_0002, 32'h4, 32'h8, -1, 0);
        fetch(0, 0, 2, 32'hAAAA_0003, 32'h8, 32'hC, -1, 0);
        chk("seq_pc_cur", pc_cur, 32'hC);

        // pc_write together with fetch_start.
        fetch(1, 32'h40, 1, 32'hBBBB_0040, 32'h40, 32'h44, -1, 0);

        // Redirect mid-REQ with three wait states.
        fetch(0, 0, 3, 32'hCCCC_0044, 32'h44, 32'h100, 1, 32'h100);

        // Misaligned PC: no request, fault raised.
        @(negedge clk); pc_write = 1; pc_next = 32'h102;
        @(negedge clk); pc_write = 0; fetch_start = 1;
        @(negedge clk); fetch_start = 0;
        chk("mis_req", {31'd0, mem_req}, 32'd0);
        chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
        chk("mis_cause", {30'd0, fault_cause}, 32'd1);
        @(negedge clk);
        chk("mis_req2", {31'd0, mem_req}, 32'd0);
        fetch(1, 32'h104, 0, 32'hDDDD_0104, 32'h104, 32'h108, -1, 0);
        chk("mis_clear", {29'd0, fetch_fault, fault_cause}, 32'd0);

        // PC wraps at the top of the address space.
        fetch(1, 32'hFFFF_FFFC, 1, 32'hEEEE_FFFC, 32'hFFFF_FFFC, 32'h0, -1, 0);
        chk("wrap_fault", {31'd0, fetch_fault}, 32'd0);

        // Timeout with no redirect, then with a pending redirect.
        timeout_run(-1, 0, 32'h0);
        timeout_run(3, 32'h200, 32'h200);
        chk("to_instr_kept", instr, 32'hEEEE_FFFC);
        chk("to_pc_old_kept", pc_old, 32'hFFFF_FFFC);

        // Stale ack in IDLE is ignored.
        @(negedge clk); mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk); mem_ack = 0;
        @(negedge clk);
        chk("stale_instr", instr, 32'hEEEE_FFFC);

        // Reset mid-REQ, then a late ack.
        @(negedge clk); fetch_start = 1;
        @(negedge clk); fetch_start = 0;
        chk("mid_req", {31'd0, mem_req}, 32'd1);
        reset = 1;
        @(negedge clk); reset = 0;
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_pc", pc_cur, 32'h0);
        chk("rst_mid_cause", {30'd0, fault_cause}, 32'd0);
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk); mem_ack = 0;
        @(negedge clk);
        chk("late_ack_instr", instr, 32'h0000_0013);
        chk("late_ack_pc", pc_cur, 32'h0);

        repeat (2) @(negedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Multicycle instruction fetch stage that sits directly upstream of decode. It owns the program counter and issues one word-aligned read per fetch request to the unified memory over a req/ack handshake. It latches the returned word into the instruction register for decode and the control FSM. It also exposes the current PC, the PC of the latched instruction and PC+4 to the datapath, and reports misaligned-fetch and bus-timeout faults.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_TIMEOUT, 16, cycles in REQ without mem_ack before timeout fault (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
fetch_start  input  1  control FSM request to fetch at pc_cur (FETCH state)
pc_write  input  1  load pc_next into PC (branch/jump/writeback)
pc_next  input  XLEN  new PC value
mem_req  output  1  memory read request
mem_addr  output  XLEN  read address, equals pc_cur while mem_req=1
mem_ack  input  1  read data valid this cycle
mem_rdata  input  32  read data
instr  output  32  instruction register
instr_valid  output  1  one-cycle pulse: instr updated
pc_cur  output  XLEN  program counter
pc_old  output  XLEN  PC of the instruction held in instr (auipc/jal/branch base)
pc_plus4  output  XLEN  pc_old + 4, combinational
busy  output  1  high in REQ
fetch_fault  output  1  sticky fault flag
fault_cause  output  2  0 none, 1 misaligned PC, 2 bus timeout

Behaviour:
- Reset (sync, when reset=1 at an edge):
  - pc_cur = pc_old = RESET_PC; instr = 32'h0000_0013 (nop).
  - instr_valid, mem_req, busy and fetch_fault are 0; fault_cause = 0; timeout counter = 0; pending-PC register cleared; state = IDLE.
  - Reset overrides all other inputs in the same cycle.
- States: IDLE, REQ.
- IDLE:
  - mem_req = 0.
  - pc_write=1 sets pc_cur <= pc_next.
  - fetch_start=1 with pc_cur[1:0]==0 goes to REQ and clears fetch_fault/fault_cause.
  - fetch_start=1 with pc_cur[1:0]!=0 stays IDLE, sets fetch_fault=1, fault_cause=1, and issues no request.
  - fetch_start and pc_write together: PC loads pc_next, and the alignment check and fetch use pc_next.
- REQ:
  - mem_req = 1, busy = 1, mem_addr = pc_cur, held stable until ack.
  - mem_ack may arrive in the first REQ cycle (zero-wait memory).
  - On mem_ack: instr <= mem_rdata, pc_old <= pc_cur, pc_cur <= pc_cur+4 (or pending PC, see below), instr_valid = 1 on the following cycle only, state -> IDLE.
  - Counter increments each REQ cycle without ack. On reaching MEM_TIMEOUT: state -> IDLE, fetch_fault = 1, fault_cause = 2; instr, pc_old and pc_cur are unchanged.
- Latency:
  - fetch_start at edge N puts mem_req high in cycle N+1.
  - Ack in cycle N+1 makes instr/instr_valid visible in cycle N+2.
  - Minimum 2 cycles per fetch; one extra cycle per memory wait state.
- pc_write while in REQ:
  - pc_next is captured into a pending register; mem_addr is not changed.
  - On completion, pc_cur <= pending value instead of pc_cur+4.
  - The last pc_write received wins.
  - On timeout, the pending value is loaded into pc_cur.
- fetch_start while busy is ignored.
- mem_ack while in IDLE (stale/late) is ignored.
- Arithmetic: PC increment wraps modulo 2^XLEN (32'hFFFF_FFFC + 4 = 0, no fault).
- fetch_fault stays set until the next accepted fetch_start or reset.
- Reset during REQ: mem_req drops at the reset edge, and any in-flight ack on a later cycle is ignored.

Test Plan:
- Reset, then fetch_start; memory acks same cycle with 32'h00115093 -> mem_addr=0 in REQ; next cycle instr=32'h00115093, instr_valid=1 for exactly 1 cycle; pc_old=0, pc_cur=4, pc_plus4=4.
- Three back-to-back fetches with 2 wait states each -> mem_addr 0,4,8 held stable while unacked; each fetch takes 4 cycles; pc_cur ends at 12.
- pc_write with pc_next=32'h40 in IDLE together with fetch_start -> REQ issues mem_addr=32'h40; after ack pc_old=32'h40, pc_cur=32'h44.
- pc_write with pc_next=32'h100 mid-REQ (ack delayed 3 cycles) -> mem_addr stays at old PC; after ack pc_cur=32'h100, pc_old=old PC.
- pc_write with pc_next=32'h102, then fetch_start -> no mem_req; fetch_fault=1, fault_cause=1. Then pc_write with 32'h104 and fetch_start -> fault clears and fetch proceeds.
- Never ack with MEM_TIMEOUT=16 -> after 16 REQ cycles: fault_cause=2, busy=0, pc_cur unchanged. Also assert reset mid-REQ -> mem_req=0 next cycle, pc_cur=RESET_PC, late ack ignored.
